// File: rtl/amba3_apb_slave_mem.sv
// APB3 slave with a word-addressed storage array, programmable wait states and a
// sticky protocol-violation flag. Higher address bits alias onto the array.
module amba3_apb_slave_mem #(
  parameter int ADDR_SIZE = 32,
  parameter int DATA_SIZE = 32,
  parameter int DEPTH     = 16
) (
  input  logic                 pclk,
  input  logic                 preset_n,
  input  logic [ADDR_SIZE-1:0] paddr,
  input  logic                 psel,
  input  logic                 penable,
  input  logic                 pwrite,
  input  logic [DATA_SIZE-1:0] pwdata,
  input  logic [3:0]           wait_cycles,
  input  logic                 err_clr,
  output logic                 pready,
  output logic [DATA_SIZE-1:0] prdata,
  output logic                 proto_err
);

  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  state_t               r_state;
  logic [3:0]           r_cnt;
  logic [ADDR_SIZE-1:0] r_addr;
  logic                 r_write;
  logic [DATA_SIZE-1:0] r_wdata;
  logic                 r_proto_err;
  logic [DATA_SIZE-1:0] r_mem [DEPTH];

  state_t               w_state_nxt;
  logic [3:0]           w_cnt_nxt;
  logic                 w_latch;
  logic                 w_commit;
  logic                 w_err_set;
  logic                 w_pready;
  logic [IDX_W-1:0]     w_idx;
  logic [DATA_SIZE-1:0] w_rdata;

  assign w_idx    = r_addr[IDX_W+1:2];
  assign w_pready = (r_state == ACCESS) && (r_cnt == 4'd0);

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch to hold the old value.
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_latch     = 1'b0;
    w_commit    = 1'b0;
    w_err_set   = 1'b0;
    case (r_state)
      IDLE: begin
        if (psel && !penable) begin
          w_latch     = 1'b1;
          w_cnt_nxt   = wait_cycles;
          w_state_nxt = ACCESS;
        end else if (psel && penable) begin
          w_err_set = 1'b1;
        end
      end
      ACCESS: begin
        // Requester changed the transfer mid-flight: flag it, keep the latched copy.
        if ((paddr != r_addr) || (pwrite != r_write) || (pwdata != r_wdata)) begin
          w_err_set = 1'b1;
        end
        if (!(psel && penable)) begin
          w_err_set   = 1'b1;
          w_cnt_nxt   = 4'd0;
          w_state_nxt = IDLE;
        end else if (r_cnt != 4'd0) begin
          w_cnt_nxt = r_cnt - 4'd1;
        end else begin
          w_commit    = r_write;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      r_state     <= IDLE;
      r_cnt       <= 4'd0;
      r_addr      <= '0;
      r_write     <= 1'b0;
      r_wdata     <= '0;
      r_proto_err <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_latch) begin
        r_addr  <= paddr;
        r_write <= pwrite;
        r_wdata <= pwdata;
      end
      if (w_err_set) begin
        r_proto_err <= 1'b1;
      end else if (err_clr) begin
        r_proto_err <= 1'b0;
      end
    end
  end

  // NOTE: the array is cleared by reset, so it builds as flops rather than a RAM
  // macro; that is intended for a block this small.
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_commit) begin
      r_mem[w_idx] <= r_wdata;
    end
  end

  always_comb begin
    w_rdata = '0;
    if (w_pready && !r_write) begin
      w_rdata = r_mem[w_idx];
    end
  end

  assign pready    = w_pready;
  assign prdata    = w_rdata;
  assign proto_err = r_proto_err;

endmodule

// File: tb/tb_amba3_apb_slave_mem.sv
// Self-checking bench for amba3_apb_slave_mem: directed scenarios plus randomized
// transfers compared against a plain array model of the storage.
`timescale 1ns/1ps
module tb_amba3_apb_slave_mem;

  localparam int DEPTH = 16;

  logic        pclk = 1'b0;
  logic        preset_n;
  logic [31:0] paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [3:0]  wait_cycles;
  logic        err_clr;
  logic        pready;
  logic [31:0] prdata;
  logic        proto_err;

  logic [31:0] model [DEPTH];
  bit          exp_err;
  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          last_start;
  int          last_end;

  amba3_apb_slave_mem #(.ADDR_SIZE(32), .DATA_SIZE(32), .DEPTH(DEPTH)) dut (
    .pclk        (pclk),
    .preset_n    (preset_n),
    .paddr       (paddr),
    .psel        (psel),
    .penable     (penable),
    .pwrite      (pwrite),
    .pwdata      (pwdata),
    .wait_cycles (wait_cycles),
    .err_clr     (err_clr),
    .pready      (pready),
    .prdata      (prdata),
    .proto_err   (proto_err)
  );

  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc++;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog expired");
  end

  function automatic int word_of(input logic [31:0] addr);
    return int'((addr >> 2) % DEPTH);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
    exp_err = 1'b0;
  endtask

  // One complete transfer; returns at the sample point of the pready=1 cycle.
  task automatic apb_xfer(input logic [31:0] addr, input bit wr, input logic [31:0] wd,
                          input logic [3:0] ws, input string tag);
    int          len;
    bit          seen;
    int          idx;
    logic [31:0] exp_rd;
    idx    = word_of(addr);
    exp_rd = wr ? 32'h0 : model[idx];
    @(negedge pclk);
    psel = 1'b1; penable = 1'b0; paddr = addr; pwrite = wr; pwdata = wd;
    wait_cycles = ws; err_clr = 1'b0;
    last_start = cyc;
    n_checks++;
    if (pready !== 1'b0) begin
      n_errors++; $display("FAIL %s/setup_pready: got %b expected 0", tag, pready);
    end
    len  = 1;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge pclk);
      penable     = 1'b1;
      wait_cycles = 4'($urandom);
      len++;
      if (pready === 1'b1) seen = 1'b1;
    end
    last_end = cyc;
    n_checks++;
    if (len != int'(ws) + 2) begin
      n_errors++; $display("FAIL %s/length: got %0d cycles expected %0d", tag, len, int'(ws) + 2);
    end
    n_checks++;
    if (prdata !== exp_rd) begin
      n_errors++; $display("FAIL %s/prdata: got %h expected %h", tag, prdata, exp_rd);
    end
    n_checks++;
    if (proto_err !== exp_err) begin
      n_errors++; $display("FAIL %s/proto_err: got %b expected %b", tag, proto_err, exp_err);
    end
    if (wr) model[idx] = wd;
  endtask

  task automatic bus_idle(input int n, input string tag);
    repeat (n) begin
      @(negedge pclk);
      psel = 1'b0; penable = 1'b0; err_clr = 1'b0;
      n_checks++;
      if (pready !== 1'b0 || prdata !== 32'h0) begin
        n_errors++; $display("FAIL %s/idle: got pready=%b prdata=%h expected 0/0", tag, pready, prdata);
      end
    end
  endtask

  task automatic clear_err(input string tag);
    @(negedge pclk);
    psel = 1'b0; penable = 1'b0; err_clr = 1'b1;
    @(negedge pclk);
    err_clr = 1'b0;
    exp_err = 1'b0;
    n_checks++;
    if (proto_err !== 1'b0) begin
      n_errors++; $display("FAIL %s/err_clr: got %b expected 0", tag, proto_err);
    end
  endtask

  task automatic apply_reset(input string tag);
    @(negedge pclk);
    #2 preset_n = 1'b0;
    #1;
    n_checks++;
    if (pready !== 1'b0 || prdata !== 32'h0 || proto_err !== 1'b0) begin
      n_errors++;
      $display("FAIL %s/reset_outputs: got pready=%b prdata=%h proto_err=%b expected 0/0/0",
               tag, pready, prdata, proto_err);
    end
    repeat (2) @(negedge pclk);
    psel = 1'b0; penable = 1'b0; err_clr = 1'b0;
    preset_n = 1'b1;
    model_clear();
  endtask

  task automatic test_reset();
    apply_reset("reset");
    bus_idle(2, "reset");
    apb_xfer(32'h0000_0000, 1'b0, 32'h0, 4'd0, "reset_rd0");
    apb_xfer(32'h0000_003C, 1'b0, 32'h0, 4'd1, "reset_rd15");
  endtask

  task automatic test_basic();
    apb_xfer(32'h0000_0004, 1'b1, 32'hDEAD_BEEF, 4'd0, "basic_wr");
    bus_idle(1, "basic");
    apb_xfer(32'h0000_0004, 1'b0, 32'h0, 4'd0, "basic_rd");
    bus_idle(1, "basic");
  endtask

  task automatic test_wait_states();
    apply_reset("wait");
    apb_xfer(32'h0000_0008, 1'b0, 32'h0, 4'd3, "wait3_rd");
    bus_idle(1, "wait");
    apb_xfer(32'h0000_0008, 1'b1, 32'hCAFE_0008, 4'd15, "wait15_wr");
    apb_xfer(32'h0000_0008, 1'b0, 32'h0, 4'd7, "wait7_rd");
    bus_idle(1, "wait");
  endtask

  task automatic test_alias();
    apb_xfer(32'h0000_0040, 1'b1, 32'h1111_1111, 4'd0, "alias_wr");
    apb_xfer(32'h0000_0000, 1'b0, 32'h0, 4'd0, "alias_rd0");
    apb_xfer(32'h0000_003C, 1'b0, 32'h0, 4'd0, "alias_rd3c");
    apb_xfer(32'hFFFF_FF43, 1'b0, 32'h0, 4'd1, "alias_hi");
    bus_idle(1, "alias");
  endtask

  task automatic test_abort();
    @(negedge pclk);
    psel = 1'b1; penable = 1'b0; paddr = 32'h0000_000C; pwrite = 1'b1;
    pwdata = 32'h5A5A_5A5A; wait_cycles = 4'd2;
    @(negedge pclk);
    wait_cycles = 4'd0;
    n_checks++;
    if (pready !== 1'b0) begin
      n_errors++; $display("FAIL abort/wait_pready: got %b expected 0", pready);
    end
    @(negedge pclk);
    psel = 1'b0;
    exp_err = 1'b1;
    n_checks++;
    if (proto_err !== 1'b1 || pready !== 1'b0) begin
      n_errors++; $display("FAIL abort/flag: got proto_err=%b pready=%b expected 1/0", proto_err, pready);
    end
    bus_idle(2, "abort");
    apb_xfer(32'h0000_000C, 1'b0, 32'h0, 4'd0, "abort_rd");
    clear_err("abort");
  endtask

  task automatic test_back_to_back();
    int t0;
    apb_xfer(32'h0000_0010, 1'b1, 32'h0000_00A5, 4'd0, "b2b_wr");
    t0 = last_start;
    apb_xfer(32'h0000_0010, 1'b0, 32'h0, 4'd0, "b2b_rd");
    n_checks++;
    if (last_end - t0 + 1 != 4) begin
      n_errors++; $display("FAIL b2b/total: got %0d cycles expected 4", last_end - t0 + 1);
    end
    bus_idle(1, "b2b");
  endtask

  task automatic test_protocol();
    @(negedge pclk);
    psel = 1'b1; penable = 1'b1; paddr = 32'h0000_0024; pwrite = 1'b1; pwdata = 32'hFEED_0024;
    @(negedge pclk);
    exp_err = 1'b1;
    err_clr = 1'b1;
    n_checks++;
    if (proto_err !== 1'b1 || pready !== 1'b0) begin
      n_errors++; $display("FAIL proto/idle_enable: got proto_err=%b pready=%b expected 1/0", proto_err, pready);
    end
    @(negedge pclk);
    n_checks++;
    if (proto_err !== 1'b1) begin
      n_errors++; $display("FAIL proto/set_wins: got %b expected 1", proto_err);
    end
    clear_err("proto");
    apb_xfer(32'h0000_0024, 1'b0, 32'h0, 4'd0, "proto_nowrite");
    // pwdata changed during access: the latched data must be written
    @(negedge pclk);
    psel = 1'b1; penable = 1'b0; paddr = 32'h0000_0020; pwrite = 1'b1;
    pwdata = 32'h0000_0077; wait_cycles = 4'd1;
    @(negedge pclk);
    penable = 1'b1; pwdata = 32'hBAD0_BAD0;
    @(negedge pclk);
    n_checks++;
    if (pready !== 1'b1 || proto_err !== 1'b1) begin
      n_errors++; $display("FAIL proto/wdata_change: got pready=%b proto_err=%b expected 1/1", pready, proto_err);
    end
    model[word_of(32'h20)] = 32'h0000_0077;
    exp_err = 1'b1;
    // paddr changed during access: the latched address must be written
    @(negedge pclk);
    psel = 1'b1; penable = 1'b0; paddr = 32'h0000_0028; pwrite = 1'b1;
    pwdata = 32'h0000_0099; wait_cycles = 4'd0;
    @(negedge pclk);
    penable = 1'b1; paddr = 32'h0000_002C;
    model[word_of(32'h28)] = 32'h0000_0099;
    apb_xfer(32'h0000_0020, 1'b0, 32'h0, 4'd0, "proto_rd20");
    apb_xfer(32'h0000_0028, 1'b0, 32'h0, 4'd0, "proto_rd28");
    apb_xfer(32'h0000_002C, 1'b0, 32'h0, 4'd0, "proto_rd2c");
    clear_err("proto_end");
  endtask

  task automatic test_reset_mid();
    @(negedge pclk);
    psel = 1'b1; penable = 1'b1; paddr = 32'h0000_0014; pwrite = 1'b1;
    @(negedge pclk);
    penable = 1'b0; pwdata = 32'h1234_5678; wait_cycles = 4'd4;
    n_checks++;
    if (proto_err !== 1'b1) begin
      n_errors++; $display("FAIL rstmid/preflag: got %b expected 1", proto_err);
    end
    @(negedge pclk);
    penable = 1'b1;
    @(negedge pclk);
    #2 preset_n = 1'b0;
    #1;
    n_checks++;
    if (pready !== 1'b0 || prdata !== 32'h0 || proto_err !== 1'b0) begin
      n_errors++;
      $display("FAIL rstmid/outputs: got pready=%b prdata=%h proto_err=%b expected 0/0/0",
               pready, prdata, proto_err);
    end
    @(negedge pclk);
    psel = 1'b0; penable = 1'b0;
    preset_n = 1'b1;
    model_clear();
    bus_idle(2, "rstmid");
    apb_xfer(32'h0000_0014, 1'b0, 32'h0, 4'd0, "rstmid_rd14");
    apb_xfer(32'h0000_0020, 1'b0, 32'h0, 4'd0, "rstmid_rd20");
    apb_xfer(32'h0000_0010, 1'b0, 32'h0, 4'd2, "rstmid_rd10");
    bus_idle(1, "rstmid");
  endtask

  task automatic test_random();
    logic [31:0] addr;
    logic [31:0] wd;
    logic [3:0]  ws;
    bit          wr;
    for (int i = 0; i < 150; i++) begin
      addr = $urandom;
      wd   = $urandom;
      wr   = 1'($urandom_range(0, 1));
      ws   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 2));
      apb_xfer(addr, wr, wd, ws, "random");
      bus_idle(int'($urandom_range(0, 2)), "random");
    end
    for (int i = 0; i < DEPTH; i++) begin
      apb_xfer(32'(i * 4), 1'b0, 32'h0, 4'd0, "final_dump");
    end
    bus_idle(1, "random");
  endtask

  initial begin
    preset_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; wait_cycles = '0; err_clr = 1'b0;
    model_clear();
    test_reset();
    test_basic();
    test_wait_states();
    test_alias();
    test_abort();
    test_back_to_back();
    test_protocol();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/amba3_apb_slave_mem.md
AMBA3_APB_SLAVE_MEM -- requirements
Module: amba3_apb_slave_mem

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: ports pclk and preset_n.
REQ-002 Parameter ADDR_SIZE, default 32, SHALL set the paddr width.
REQ-003 Parameter DATA_SIZE, default 32, SHALL set the pwdata/prdata width.
REQ-004 Parameter DEPTH, default 16 (power of 2, >=2), SHALL set the number of DATA_SIZE-bit storage words.
REQ-005 pclk  in  1  APB clock; all state updates on the rising edge.
REQ-006 preset_n  in  1  asynchronous active-low reset.
REQ-007 paddr  in  ADDR_SIZE  byte address from the requester.
REQ-008 psel  in  1  slave select.
REQ-009 penable  in  1  access-phase strobe.
REQ-010 pwrite  in  1  1=write, 0=read.
REQ-011 pwdata  in  DATA_SIZE  write data.
REQ-012 pready  out  1  transfer-complete strobe.
REQ-013 prdata  out  DATA_SIZE  read data.
REQ-014 wait_cycles  in  4  wait states to insert; sampled at the setup edge.
REQ-015 proto_err  out  1  sticky protocol-violation flag.
REQ-016 err_clr  in  1  synchronous clear of proto_err.

Function
REQ-017 Word index SHALL be paddr[log2(DEPTH)+1:2]; paddr[1:0] and the bits above the index SHALL be ignored, so higher addresses alias.
REQ-018 The FSM SHALL have exactly two states: IDLE and ACCESS.
REQ-019 IDLE, edge with psel=1, penable=0: latch index, pwrite, pwdata; load cnt=wait_cycles; go to ACCESS.
REQ-020 IDLE, edge with psel=1, penable=1: set proto_err and stay in IDLE, with no access performed.
REQ-021 pready SHALL equal (state==ACCESS && cnt==0); it SHALL be 0 in every other cycle.
REQ-022 ACCESS, edge with psel=1, penable=1, cnt!=0: decrement cnt.
REQ-023 ACCESS, edge with psel=1, penable=1, cnt==0: complete the transfer; a write commits the latched pwdata to the latched index at this edge; then go to IDLE.
REQ-024 Minimum transfer SHALL be 2 cycles (setup + access); total transfer length SHALL be 2+wait_cycles cycles; maximum 17.
REQ-025 Back-to-back transfers SHALL be accepted: a setup phase in the cycle right after completion is sampled from IDLE per REQ-019.
REQ-026 prdata SHALL equal mem[latched index] when pready=1 and the latched pwrite=0; otherwise it SHALL be all zeros.
REQ-027 ACCESS, edge with psel=0 or penable=0 before completion: set proto_err, abort with no write, go to IDLE; a psel=1, penable=0 sample there SHALL NOT start a new transfer.
REQ-028 ACCESS, edge where paddr, pwrite or pwdata differ from the latched values: set proto_err; the transfer SHALL continue using the latched values.
REQ-029 proto_err SHALL stay set until an edge with err_clr=1; if a new violation occurs at the same edge, set SHALL win.
REQ-030 Writes SHALL affect only the addressed word; reads SHALL have no side effects.

Reset
REQ-031 While preset_n=0, the block SHALL force state=IDLE, cnt=0, pready=0, prdata=0, proto_err=0, and every memory word to 0, independent of pclk.
REQ-032 Reset asserted mid-transfer SHALL abort the transfer with no write; after release the block SHALL wait for a fresh setup phase.

Verification
REQ-033 wait_cycles=0; write 0xDEADBEEF to 0x04; read 0x04 -> pready in the 2nd cycle of each transfer, read prdata=0xDEADBEEF, proto_err=0.
REQ-034 wait_cycles=3; read 0x08 after reset -> pready low for 3 access cycles, high in the 4th, prdata=0x00000000, transfer length 5 cycles.
REQ-035 DEPTH=16; write 0x11111111 to 0x40; read 0x00 -> 0x11111111 (alias); read 0x3C -> 0x00000000.
REQ-036 wait_cycles=2; write 0x5A5A5A5A to 0x0C; drop penable during the 1st wait cycle -> proto_err=1; later read 0x0C returns 0x00000000; err_clr pulse -> proto_err=0.
REQ-037 wait_cycles=0; back-to-back write 0xA5 to 0x10 then read 0x10 with no idle gap -> 4 cycles total, read prdata=0x000000A5.
REQ-038 wait_cycles=4; assert preset_n=0 during the 2nd wait cycle of a write of 0x12345678 to 0x14 -> pready=0 and prdata=0 immediately; after release, read 0x14 returns 0x00000000.
